// File: rtl/foo_pack_pkg.sv
// Shared constants and helpers for the foo byte-lane to word packer.
package foo_pack_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 32;

  // o_count has to represent 1..N, hence one bit above the lane index width.
  function automatic int count_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int lane_offset(input int lane, input int n, input int in_w,
                                     input bit lsb_first);
    return lsb_first ? lane * in_w : (n - 1 - lane) * in_w;
  endfunction

endpackage

// File: rtl/foo_pack_out_reg.sv
// Output holding register: keeps a packed word stable until the consumer takes it.
module foo_pack_out_reg #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             slot_free
);

  assign slot_free = !o_valid || o_ready;

  // A load in the same cycle as a drain wins, giving back-to-back words.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= load_data;
      o_count <= load_count;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/foo_word_packer.sv
// Packs IN_W-bit lanes from the foo field into OUT_W-bit words; flush emits a zero-padded partial word.
module foo_word_packer
  import foo_pack_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_valid,
  output logic                                i_ready,
  input  logic [IN_W-1:0]                     i_data,
  input  logic                                i_flush,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic [OUT_W-1:0]                    o_data,
  output logic [count_w(OUT_W/IN_W)-1:0]      o_count
);

  localparam int N      = OUT_W / IN_W;
  localparam int LANE_W = $clog2(N);
  localparam int CNT_W  = count_w(N);

  logic [LANE_W-1:0] lane, lane_d;
  logic [OUT_W-1:0]  assembly, assembly_d, assembly_next, lane_bits;
  logic              flush_pend, flush_pend_d;
  logic [CNT_W-1:0]  filled;
  logic              accept, last, flush_req, slot_free;
  logic              load;
  logic [OUT_W-1:0]  load_data;
  logic [CNT_W-1:0]  load_count;

  // Only the last lane needs the output slot, so earlier lanes never stall.
  assign i_ready = !flush_pend && (lane != LANE_W'(N - 1) || slot_free);

  always_comb begin
    accept        = i_valid && i_ready;
    lane_bits     = '0;
    if (accept)
      lane_bits = OUT_W'(i_data) << lane_offset(int'(lane), N, IN_W, LSB_FIRST);
    assembly_next = assembly | lane_bits;
    filled        = {1'b0, lane} + CNT_W'(accept);
    last          = accept && (lane == LANE_W'(N - 1));
    flush_req     = i_flush && !flush_pend;

    lane_d        = accept ? lane + LANE_W'(1) : lane;
    assembly_d    = assembly_next;
    flush_pend_d  = flush_pend;
    load          = 1'b0;
    load_data     = assembly_next;
    load_count    = filled;

    // A full word takes precedence; a same-cycle flush adds nothing.
    if (last) begin
      load       = 1'b1;
      lane_d     = '0;
      assembly_d = '0;
    end else if (flush_pend) begin
      if (slot_free) begin
        load         = 1'b1;
        lane_d       = '0;
        assembly_d   = '0;
        flush_pend_d = 1'b0;
      end
    end else if (flush_req && filled != '0) begin
      if (slot_free) begin
        load       = 1'b1;
        lane_d     = '0;
        assembly_d = '0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      assembly   <= '0;
      flush_pend <= 1'b0;
    end else begin
      lane       <= lane_d;
      assembly   <= assembly_d;
      flush_pend <= flush_pend_d;
    end
  end

  foo_pack_out_reg #(
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_count(load_count),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_count   (o_count),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_foo_word_packer.sv
// Randomised and directed bench for foo_word_packer; both lane orders run side by side against a lane-queue model.
module tb_foo_word_packer;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_flush;
  logic        o_ready;
  logic        ready_l, ready_m;
  logic        valid_l, valid_m;
  logic [31:0] data_l, data_m;
  logic [2:0]  count_l, count_m;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] cur_lanes[$];
  logic [7:0] held_lanes[$];
  bit         held_valid;
  bit         pending;

  foo_word_packer #(.IN_W(8), .OUT_W(32), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ready_l), .i_data(i_data),
    .i_flush(i_flush), .o_valid(valid_l), .o_ready(o_ready), .o_data(data_l), .o_count(count_l)
  );

  foo_word_packer #(.IN_W(8), .OUT_W(32), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ready_m), .i_data(i_data),
    .i_flush(i_flush), .o_valid(valid_m), .o_ready(o_ready), .o_data(data_m), .o_count(count_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // First lane taken goes to the bottom byte (lsb) or the top byte (msb); unused bytes are zero.
  function automatic logic [31:0] packWord(input logic [7:0] lanes[$], input bit lsb);
    logic [31:0] w = '0;
    for (int i = 0; i < lanes.size(); i++)
      w += 32'(lanes[i]) << (8 * (lsb ? i : N - 1 - i));
    return w;
  endfunction

  task automatic checkHeld();
    checkOutput("o_valid_lsb", 32'(valid_l), 32'(held_valid));
    checkOutput("o_valid_msb", 32'(valid_m), 32'(held_valid));
    if (held_valid) begin
      checkOutput("o_data_lsb", data_l, packWord(held_lanes, 1'b1));
      checkOutput("o_data_msb", data_m, packWord(held_lanes, 1'b0));
      checkOutput("o_count_lsb", 32'(count_l), 32'(held_lanes.size()));
      checkOutput("o_count_msb", 32'(count_m), 32'(held_lanes.size()));
    end
  endtask

  task automatic doReset();
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; o_ready = 1'b0; i_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_lanes.delete(); held_lanes.delete(); held_valid = 1'b0; pending = 1'b0;
    checkOutput("rst_o_valid", 32'(valid_l), 32'd0);
    checkOutput("rst_o_data_lsb", data_l, 32'd0);
    checkOutput("rst_o_data_msb", data_m, 32'd0);
    checkOutput("rst_o_count", 32'(count_l), 32'd0);
    checkOutput("rst_i_ready", 32'(ready_l), 32'd1);
  endtask

  // One clock: drive at the falling edge, predict i_ready, update the model at the rising edge.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit r);
    bit exp_ready, accepted, slot_free, emitted;
    i_valid = v; i_data = d; i_flush = f; o_ready = r;
    #1;
    slot_free = !held_valid || r;
    exp_ready = !pending && (cur_lanes.size() != N - 1 || slot_free);
    checkOutput("i_ready_lsb", 32'(ready_l), 32'(exp_ready));
    checkOutput("i_ready_msb", 32'(ready_m), 32'(exp_ready));
    accepted = v && exp_ready;
    @(posedge clk);
    emitted = 1'b0;
    if (accepted) cur_lanes.push_back(d);
    if (cur_lanes.size() == N) begin
      emitted = 1'b1;
    end else if (pending) begin
      if (slot_free) begin emitted = 1'b1; pending = 1'b0; end
    end else if (f && cur_lanes.size() > 0) begin
      if (slot_free) emitted = 1'b1;
      else pending = 1'b1;
    end
    if (emitted) begin
      held_lanes = cur_lanes;
      cur_lanes.delete();
      held_valid = 1'b1;
    end else if (held_valid && r) begin
      held_valid = 1'b0;
    end
    @(negedge clk);
    checkHeld();
  endtask

  task automatic sendLanes(input logic [7:0] first, input int count, input logic [7:0] step, input bit r);
    for (int i = 0; i < count; i++) applyStimulus(1'b1, first + 8'(i) * step, 1'b0, r);
  endtask

  initial begin
    doReset();

    // Single word with a low nonzero lane and zero lanes above it.
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b1);
    sendLanes(8'h00, 3, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Back-to-back words at full rate.
    sendLanes(8'h11, 8, 8'h11, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Consumer stalled: the last lane of the second word must wait.
    sendLanes(8'h11, 7, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush of a partial word, flush at lane 0, flush with a lane in the same cycle.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush on the last lane, then flush while the output is held (pending flush).
    sendLanes(8'h21, 3, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h24, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a word discards partial lanes.
    sendLanes(8'h51, 3, 8'h01, 1'b1);
    doReset();
    sendLanes(8'h01, 4, 8'h01, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      else applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                         $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/foo_word_packer.md
Name: foo_word_packer

Overview:
Packs a narrow byte stream, taken from the 8-bit `foo` field of an interface, back into full-width data words. It is the widening counterpart of the narrowing cast `$bits(foo)'(data)` used when driving that interface. It sits on the receive side of the interface and feeds a 32-bit consumer. Both sides use valid/ready handshakes. A flush input emits a partial word, zero-extended, the same way a widening cast pads.

Parameters:
IN_W, 8, lane width in bits; matches the width of the interface `foo` field
OUT_W, 32, output word width; must be an integer multiple of IN_W, with N = OUT_W/IN_W >= 2
LSB_FIRST, 1, 1 = first accepted lane lands in bits [IN_W-1:0]; 0 = first lane lands in the top lane

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
i_valid  in  1  input lane valid
i_ready  out  1  packer can accept a lane
i_data  in  IN_W  lane data (the interface `foo` value)
i_flush  in  1  single-cycle request to emit the current partial word
o_valid  out  1  output word valid
o_ready  in  1  consumer accepts the word
o_data  out  OUT_W  packed word
o_count  out  $clog2(N)+1  number of valid lanes in o_data (1..N)

Behaviour:
- Reset (rst=1 at a clk edge): o_valid=0, o_data=0, o_count=0, lane index=0, assembly register=0, flush_pend=0. i_ready=1 in the first cycle after reset.
- rst has priority over every other input. Reset in the middle of a word discards the partial lanes and any held output word.
- Accept condition is i_valid && i_ready. An accepted lane k (k = lane index) is written to bits [k*IN_W +: IN_W] when LSB_FIRST=1, or to bits [(N-1-k)*IN_W +: IN_W] when LSB_FIRST=0.
- Lane index counts 0..N-1 and wraps to 0 after the last lane is accepted.
- Output slot is "free" when !o_valid || o_ready.
- i_ready = !flush_pend && (lane != N-1 || slot free). The packer stalls only on the last lane, and only when the output is held. Full throughput of one word per N cycles is sustained.
- Last lane accepted: at the same edge, o_data <= assembled word including this lane, o_count <= N, o_valid <= 1, and the assembly register clears. Latency is one cycle from the last lane accept to o_valid.
- o_valid stays high and o_data/o_count stay stable until o_valid && o_ready. The drop of o_valid and a new load may happen at the same edge (back-to-back words).
- Flush with lane index > 0 (counting a lane accepted in the same cycle):
  - Slot free: o_data <= partial word with unused lanes zero, o_count <= lanes filled, o_valid <= 1, lane index <= 0.
  - Slot not free: flush_pend <= 1; i_ready=0 until the slot frees, then emit as above and clear flush_pend.
- Flush with lane index = 0 and no lane accepted that cycle: no effect and no output.
- Flush in the same cycle as the last lane: a normal full word is emitted (o_count=N); nothing extra.
- i_flush is ignored while flush_pend=1.
- Unsigned arithmetic only; no sign extension, padding is always zero.

Decomposition:
- Package foo_pack_pkg: default IN_W/OUT_W constants, count-width function, and the lane-position function (lane index to bit offset, honouring LSB_FIRST).
- One sub-module, foo_pack_out_reg: the output holding register with valid/ready, load, and slot-free logic.
- Lane counter, assembly register, and flush_pend stay in the top level.

Test Plan:
1. LSB_FIRST=1, o_ready=1, lanes 05,00,00,00 -> one cycle later o_data=32'h00000005, o_count=4, o_valid for 1 cycle.
2. 8 back-to-back lanes 11..88, o_ready=1 -> words 32'h44332211 then 32'h88776655; i_ready never drops.
3. o_ready=0, offer 8 lanes 11..88 -> i_ready low on lane 88; word 44332211 stays stable; when o_ready=1 for one cycle, 88 is accepted and 88776655 follows.
4. Lanes AA,BB then i_flush -> o_data=32'h0000BBAA, o_count=2. A later i_flush at lane 0 -> no o_valid. i_flush together with a 3rd lane CC -> 32'h00CCBBAA, o_count=3.
5. LSB_FIRST=0, lanes 11,22,33,44 -> 32'h11223344. Flush after 11 -> 32'h11000000, o_count=1.
6. Three lanes, then rst for 1 cycle -> all outputs 0. Next lanes 01..04 -> 32'h04030201, with no stale lanes.
